wishbone_bus_if: RTL and testbench

- Bridges one CPU-side memory port onto a Wishbone B3 classic single-transfer master.
- CPU-side signals: ce/we/sel/addr/data, identical to the core's ROM/RAM ports.
- Two instances sit directly downstream of the core, one for the instruction port and one for the data port, and feed the system bus.
- Holds the pipeline through the ctrl stall network until the slave acknowledges, then returns read data. Supports flush and a bus-timeout abort.

---
 rtl/wishbone_bus_if.sv | 169 ++++++++++++++++
 tb/tb_wishbone_bus_if.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if.sv
// Bridges one CPU-side memory port onto a Wishbone B3 classic single-transfer master.
// Holds the pipeline via stallreq_o until ack, flush or watchdog timeout ends the transfer.
module wishbone_bus_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall_i,
    input  logic                  flush_i,
    input  logic                  cpu_ce_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W-1:0]     cpu_data_i,
    input  logic                  cpu_we_i,
    input  logic [DATA_W/8-1:0]   cpu_sel_i,
    output logic [DATA_W-1:0]     cpu_data_o,
    output logic                  stallreq_o,
    output logic                  bus_err_o,
    input  logic [DATA_W-1:0]     wishbone_data_i,
    input  logic                  wishbone_ack_i,
    output logic [ADDR_W-1:0]     wishbone_addr_o,
    output logic [DATA_W-1:0]     wishbone_data_o,
    output logic                  wishbone_we_o,
    output logic [DATA_W/8-1:0]   wishbone_sel_o,
    output logic                  wishbone_stb_o,
    output logic                  wishbone_cyc_o,
    output logic [1:0]            dbg_state
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               cyc_q;
    logic [DATA_W-1:0]  rd_buf;
    logic [CNT_W-1:0]   count;
    logic               timeout_hit;
    logic               stall_any;
    logic               start;

    assign timeout_hit = (TIMEOUT != 0) && (count == TO_LAST);
    assign stall_any   = |stall_i;
    assign start       = cpu_ce_i && !flush_i;

    // stb and cyc come from one flop so they can never disagree.
    assign wishbone_stb_o = cyc_q;
    assign wishbone_cyc_o = cyc_q;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (wishbone_ack_i || timeout_hit) begin
                    state_nxt = stall_any ? WAIT_STALL : IDLE;
                end
            end
            WAIT_STALL: begin
                if (!stall_any || flush_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            BUSY: begin
                if (!flush_i && wishbone_ack_i) begin
                    cpu_data_o = wishbone_we_o ? '0 : wishbone_data_i;
                end else if (!flush_i && timeout_hit) begin
                    stallreq_o = 1'b0;
                end else begin
                    stallreq_o = ~flush_i;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf;
            end
            default: ;
        endcase
    end

    // Bus-side registers, read buffer, watchdog and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q           <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            rd_buf          <= '0;
            count           <= '0;
            bus_err_o       <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cyc_q           <= 1'b1;
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        count           <= '0;
                    end
                end
                BUSY: begin
                    if (flush_i || wishbone_ack_i || timeout_hit) begin
                        cyc_q           <= 1'b0;
                        wishbone_addr_o <= '0;
                        wishbone_data_o <= '0;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= {SEL_W{1'b0}};
                    end
                    if (flush_i) begin
                        rd_buf <= '0;
                    end else if (wishbone_ack_i) begin
                        if (!wishbone_we_o) begin
                            rd_buf <= wishbone_data_i;
                        end
                    end else if (timeout_hit) begin
                        rd_buf    <= '0;
                        bus_err_o <= 1'b1;
                    end else if (count != {CNT_W{1'b1}}) begin
                        count <= count + CNT_W'(1);
                    end
                end
                WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if with a read-data scoreboard.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wishbone_bus_if;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TIMEOUT = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [5:0]          stall_i = '0;
    logic                flush_i = 1'b0;
    logic                cpu_ce_i = 1'b0;
    logic [ADDR_W-1:0]   cpu_addr_i = '0;
    logic [DATA_W-1:0]   cpu_data_i = '0;
    logic                cpu_we_i = 1'b0;
    logic [3:0]          cpu_sel_i = '0;
    logic [DATA_W-1:0]   cpu_data_o;
    logic                stallreq_o;
    logic                bus_err_o;
    logic [DATA_W-1:0]   wishbone_data_i = '0;
    logic                wishbone_ack_i = 1'b0;
    logic [ADDR_W-1:0]   wishbone_addr_o;
    logic [DATA_W-1:0]   wishbone_data_o;
    logic                wishbone_we_o;
    logic [3:0]          wishbone_sel_o;
    logic                wishbone_stb_o;
    logic                wishbone_cyc_o;
    logic [1:0]          dbg_state;

    logic [DATA_W-1:0]   exp_q[$];
    int                  compared = 0;
    int                  mismatched = 0;

    wishbone_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
        .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
        .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_stb"}, 64'(wishbone_stb_o), 64'd0);
        check({tag, "_cyc"}, 64'(wishbone_cyc_o), 64'd0);
        check({tag, "_addr"}, 64'(wishbone_addr_o), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // Read transfer: slave data goes on the scoreboard when the ack is driven.
    task automatic bus_read(input logic [31:0] addr, input logic [31:0] rdata, input int waits);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = addr; cpu_sel_i = 4'hF;
        #1;
        check("rd_req_stallreq", 64'(stallreq_o), 64'd1);
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            #1;
            check("rd_stb", 64'(wishbone_stb_o), 64'd1);
            check("rd_addr", 64'(wishbone_addr_o), 64'(addr));
            check("rd_we", 64'(wishbone_we_o), 64'd0);
            if (i < waits) begin
                check("rd_wait_stallreq", 64'(stallreq_o), 64'd1);
                check("rd_wait_data", 64'(cpu_data_o), 64'd0);
                tick();
            end
        end
        wishbone_ack_i = 1'b1; wishbone_data_i = rdata;
        exp_q.push_back(rdata);
        #1;
        check("rd_ack_stallreq", 64'(stallreq_o), 64'd0);
        if (exp_q.size() > 0) check("rd_ack_data", 64'(cpu_data_o), 64'(exp_q.pop_front()));
        tick();
        wishbone_ack_i = 1'b0; wishbone_data_i = $urandom;
        #1;
        check_idle_bus("rd_done");
    endtask

    // Write acked under stall: cpu_data_o then shows rd_buf, which must be cleared.
    task automatic write_under_stall(input string tag);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0900;
        cpu_data_i = 32'hA5A5_0000; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; stall_i = 6'b000001;
        tick();
        wishbone_ack_i = 1'b0;
        #1;
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_WAIT));
        check({tag, "_rdbuf"}, 64'(cpu_data_o), 64'd0);
        stall_i = '0;
        tick();
    endtask

    initial begin
        // Reset
        #1;
        check("rst_stb", 64'(wishbone_stb_o), 64'd0);
        check("rst_cyc", 64'(wishbone_cyc_o), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_err", 64'(bus_err_o), 64'd0);
        check("rst_data", 64'(cpu_data_o), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: read with single-cycle ack
        bus_read(32'h0000_0100, 32'hDEAD_BEEF, 0);

        // 2: write with three wait states
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'b0011;
        cpu_data_i = 32'h1234_5678; cpu_addr_i = 32'h0000_0200;
        tick();
        for (int i = 0; i < 3; i++) begin
            cpu_data_i = $urandom; cpu_addr_i = $urandom; cpu_sel_i = 4'($urandom);
            #1;
            check("wr_stb", 64'(wishbone_stb_o), 64'd1);
            check("wr_addr", 64'(wishbone_addr_o), 64'h200);
            check("wr_data", 64'(wishbone_data_o), 64'h1234_5678);
            check("wr_we", 64'(wishbone_we_o), 64'd1);
            check("wr_sel", 64'(wishbone_sel_o), 64'b0011);
            check("wr_stallreq", 64'(stallreq_o), 64'd1);
            check("wr_cpu_data", 64'(cpu_data_o), 64'd0);
            tick();
        end
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hFFFF_FFFF;
        #1;
        check("wr_ack_stallreq", 64'(stallreq_o), 64'd0);
        check("wr_ack_data", 64'(cpu_data_o), 64'd0);
        tick();
        wishbone_ack_i = 1'b0;
        #1;
        check_idle_bus("wr_done");

        // 3: read acked under external stall
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0300;
        tick();
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hCAFE_0001;
        stall_i = 6'b000111;
        exp_q.push_back(32'hCAFE_0001);
        #1;
        if (exp_q.size() > 0) check("stl_ack_data", 64'(cpu_data_o), 64'(exp_q.pop_front()));
        tick();
        wishbone_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wishbone_data_i = $urandom;
            #1;
            check("stl_state", 64'(dbg_state), 64'(ST_WAIT));
            check("stl_hold_data", 64'(cpu_data_o), 64'hCAFE_0001);
            check("stl_stallreq", 64'(stallreq_o), 64'd0);
            check("stl_stb", 64'(wishbone_stb_o), 64'd0);
            tick();
        end
        stall_i = '0; wishbone_ack_i = 1'b1;
        #1;
        check("stl_last_data", 64'(cpu_data_o), 64'hCAFE_0001);
        tick();
        wishbone_ack_i = 1'b0;
        #1;
        check("stl_exit_state", 64'(dbg_state), 64'(ST_IDLE));
        check("stl_exit_data", 64'(cpu_data_o), 64'd0);

        // 4: flush beats ack in BUSY; flush suppresses a request in IDLE
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0400;
        tick();
        cpu_ce_i = 1'b0; flush_i = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h5555_5555;
        #1;
        check("fl_stallreq", 64'(stallreq_o), 64'd0);
        check("fl_data", 64'(cpu_data_o), 64'd0);
        tick();
        wishbone_ack_i = 1'b0; cpu_ce_i = 1'b1;
        #1;
        check_idle_bus("fl_done");
        check("fl_idle_stallreq", 64'(stallreq_o), 64'd0);
        tick();
        flush_i = 1'b0; cpu_ce_i = 1'b0;
        #1;
        check_idle_bus("fl_idle");
        write_under_stall("fl_rdbuf");

        // Random reads with random wait states
        for (int n = 0; n < 4; n++) begin
            bus_read($urandom, $urandom, $urandom_range(0, 2));
        end

        // 5: watchdog timeout
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0500;
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            check("to_stb", 64'(wishbone_stb_o), 64'd1);
            check("to_err_low", 64'(bus_err_o), 64'd0);
            check("to_stallreq", 64'(stallreq_o), (i == TIMEOUT - 1) ? 64'd0 : 64'd1);
            tick();
        end
        #1;
        check_idle_bus("to_done");
        check("to_err_pulse", 64'(bus_err_o), 64'd1);
        check("to_data", 64'(cpu_data_o), 64'd0);
        tick();
        #1;
        check("to_err_clear", 64'(bus_err_o), 64'd0);
        write_under_stall("to_rdbuf");

        // 6: asynchronous reset during BUSY
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0600;
        tick();
        cpu_ce_i = 1'b0;
        #1;
        check("ar_stb_before", 64'(wishbone_stb_o), 64'd1);
        rst = 1'b0;
        #1;
        check("ar_stb_async", 64'(wishbone_stb_o), 64'd0);
        check("ar_cyc_async", 64'(wishbone_cyc_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_bus("ar_release");
        tick();
        bus_read(32'h0000_0700, 32'h0BAD_F00D, 1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
